// File: rtl/invader_march.sv
`default_nettype none
// ============================================================================
// invader_march : fixed-point formation march controller (right/down/left/down)
// Rev 1.0 : initial release
// ============================================================================
module invader_march #(
  parameter int FRAC_BITS  = 6,
  parameter int INIT_X     = 20,
  parameter int INIT_Y     = 20,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 639,
  parameter int FORM_W     = 320,
  parameter int STEP_DOWN  = 16,
  parameter int X_SPD_INIT = 60,
  parameter int X_SPD_STEP = 1,
  parameter int X_SPD_MAX  = 512,
  parameter int WAVE_BONUS = 8,
  parameter int Y_SPD      = 64,
  parameter int Y_LIMIT    = 400
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        idleN,
  input  logic        speedUp,
  input  logic        newWave,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        dirRight,
  output logic        landed,
  output logic [3:0]  waveNum
);

  localparam int P = 11 + FRAC_BITS;
  localparam int W = 12 + FRAC_BITS;

  localparam logic [W-1:0] R_WALL  = W'((X_MAX - FORM_W + 1) << FRAC_BITS);
  localparam logic [W-1:0] L_WALL  = W'(X_MIN << FRAC_BITS);
  localparam logic [W-1:0] STEP_DN = W'(STEP_DOWN << FRAC_BITS);
  localparam logic [W-1:0] Y_LIM   = W'(Y_LIMIT << FRAC_BITS);
  localparam logic [W-1:0] Y_STEP  = W'(Y_SPD);
  localparam logic [P-1:0] X_START = P'(INIT_X << FRAC_BITS);
  localparam logic [P-1:0] Y_START = P'(INIT_Y << FRAC_BITS);
  localparam logic [P-1:0] R_CLAMP = P'((X_MAX - FORM_W + 1) << FRAC_BITS);
  localparam logic [P-1:0] L_CLAMP = P'(X_MIN << FRAC_BITS);
  localparam logic [9:0]   SPD_INI = 10'(X_SPD_INIT);
  localparam logic [9:0]   SPD_MAX = 10'(X_SPD_MAX);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOV_RGT   = 3'd1,
    S_DN_TO_LFT = 3'd2,
    S_MOV_LFT   = 3'd3,
    S_DN_TO_RGT = 3'd4,
    S_LANDED    = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [P-1:0] posx_q, posx_d;
  logic [P-1:0] posy_q, posy_d;
  logic [W-1:0] tgty_q, tgty_d;
  logic [9:0]   xspd_q, xspd_d;
  logic [3:0]   wave_q, wave_d;

  logic [W-1:0] wx, wy, spd_w, x_add, x_sub, y_add;
  logic [10:0]  spd_inc;
  logic [3:0]   wave_inc;
  logic [31:0]  wave_spd;
  logic         frame;

  always_comb begin
    state_d  = state_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    tgty_d   = tgty_q;
    xspd_d   = xspd_q;
    wave_d   = wave_q;

    wx       = {1'b0, posx_q};
    wy       = {1'b0, posy_q};
    spd_w    = W'(xspd_q);
    x_add    = wx + spd_w;
    x_sub    = wx - spd_w;
    y_add    = wy + Y_STEP;
    frame    = startOfFrame & idleN;
    spd_inc  = {1'b0, xspd_q} + 11'(X_SPD_STEP);
    wave_inc = (wave_q == 4'd15) ? 4'd15 : wave_q + 4'd1;
    wave_spd = 32'(X_SPD_INIT) + 32'(wave_inc) * 32'(WAVE_BONUS);

    if (newWave) begin
      // newWave outranks everything, so a coincident speedUp is dropped
      state_d = S_IDLE;
      posx_d  = X_START;
      posy_d  = Y_START;
      wave_d  = wave_inc;
      xspd_d  = (wave_spd > 32'(X_SPD_MAX)) ? SPD_MAX : wave_spd[9:0];
    end else begin
      if (speedUp && (state_q != S_LANDED))
        xspd_d = (spd_inc > {1'b0, SPD_MAX}) ? SPD_MAX : spd_inc[9:0];

      case (state_q)
        S_IDLE: begin
          if (idleN) state_d = S_MOV_RGT;
        end
        S_MOV_RGT: begin
          if (frame) begin
            if (x_add >= R_WALL) begin
              posx_d  = R_CLAMP;
              tgty_d  = wy + STEP_DN;
              state_d = S_DN_TO_LFT;
            end else begin
              posx_d = x_add[P-1:0];
            end
          end
        end
        S_MOV_LFT: begin
          // compared before subtracting so posX can never wrap below zero
          if (frame) begin
            if (wx < L_WALL + spd_w) begin
              posx_d  = L_CLAMP;
              tgty_d  = wy + STEP_DN;
              state_d = S_DN_TO_RGT;
            end else begin
              posx_d = x_sub[P-1:0];
            end
          end
        end
        S_DN_TO_LFT, S_DN_TO_RGT: begin
          if (frame) begin
            if (y_add >= tgty_q) begin
              posy_d = tgty_q[P-1:0];
              if (tgty_q >= Y_LIM)
                state_d = S_LANDED;
              else if (state_q == S_DN_TO_LFT)
                state_d = S_MOV_LFT;
              else
                state_d = S_MOV_RGT;
            end else begin
              posy_d = y_add[P-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      posx_q  <= X_START;
      posy_q  <= Y_START;
      tgty_q  <= '0;
      xspd_q  <= SPD_INI;
      wave_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      tgty_q  <= tgty_d;
      xspd_q  <= xspd_d;
      wave_q  <= wave_d;
    end
  end

  assign topLeftX = posx_q[P-1:FRAC_BITS];
  assign topLeftY = posy_q[P-1:FRAC_BITS];
  assign dirRight = (state_q == S_IDLE) || (state_q == S_MOV_RGT) || (state_q == S_DN_TO_LFT);
  assign landed   = (state_q == S_LANDED);
  assign waveNum  = wave_q;

endmodule
`default_nettype wire

// File: tb/tb_invader_march.sv
`default_nettype none
// ============================================================================
// tb_invader_march : directed vector table plus multi-cycle march sequences
// Rev 1.0 : initial release
// ============================================================================
module tb_invader_march;

  logic        clk = 1'b0;
  logic        resetN, startOfFrame, idleN, speedUp, newWave;
  logic [10:0] topLeftX, topLeftY;
  logic        dirRight, landed;
  logic [3:0]  waveNum;

  int errors = 0;
  int checks = 0;

  invader_march dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .idleN        (idleN),
    .speedUp      (speedUp),
    .newWave      (newWave),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .dirRight     (dirRight),
    .landed       (landed),
    .waveNum      (waveNum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sof, idle, su, nw;
    int   ex, ey;
    logic edir, eland;
    int   ewave;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey,
                           input logic ed, input logic el, input int ew);
    check({tag, ".x"},     32'(topLeftX), ex);
    check({tag, ".y"},     32'(topLeftY), ey);
    check({tag, ".dir"},   32'(dirRight), int'(ed));
    check({tag, ".landed"},32'(landed),   int'(el));
    check({tag, ".wave"},  32'(waveNum),  ew);
  endtask

  task automatic cyc(input logic sof, input logic idle, input logic su, input logic nw);
    @(negedge clk);
    startOfFrame = sof;
    idleN        = idle;
    speedUp      = su;
    newWave      = nw;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    speedUp      = 1'b0;
    newWave      = 1'b0;
  endtask

  task automatic frame();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // posX = 1280 + 60k before any speedUp; coincident speedUp frame moves by 60
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 20, 20, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 20, 20, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 20, 20, 1'b1, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 20, 20, 1'b1, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 21, 20, 1'b1, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 22, 20, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 23, 20, 1'b1, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24, 20, 1'b1, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 25, 20, 1'b1, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 26, 20, 1'b1, 1'b0, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 27, 20, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 28, 20, 1'b1, 1'b0, 0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 29, 20, 1'b1, 1'b0, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 29, 20, 1'b1, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 29, 20, 1'b1, 1'b0, 0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 30, 20, 1'b1, 1'b0, 0};
    for (int i = 16; i < 25; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 30, 20, 1'b1, 1'b0, 0};

    resetN = 1'b0; startOfFrame = 1'b0; idleN = 1'b0; speedUp = 1'b0; newWave = 1'b0;
    #12;
    check_all("reset", 20, 20, 1'b1, 1'b0, 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].sof, vecs[i].idle, vecs[i].su, vecs[i].nw);
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                vecs[i].edir, vecs[i].eland, vecs[i].ewave);
    end

    // xSpd = 70: 64 frames from posX 1940 -> 6420 (100 px)
    repeat (64) frame();
    check("speed70.x", 32'(topLeftX), 100);

    n = 0;
    while (topLeftX != 11'd320 && n < 400) begin
      frame();
      n++;
    end
    check("rwall.frames", 32'(n), 201);
    check_all("rwall", 320, 20, 1'b1, 1'b0, 0);

    for (int j = 1; j <= 16; j++) begin
      frame();
      check($sformatf("descR%0d.y", j), 32'(topLeftY), 20 + j);
      check($sformatf("descR%0d.dir", j), 32'(dirRight), (j < 16) ? 1 : 0);
      if (j == 8) begin
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("freeze", 320, 28, 1'b1, 1'b0, 0);
      end
    end
    check("descR.x", 32'(topLeftX), 320);

    repeat (500) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("sat_hold", 320, 36, 1'b0, 1'b0, 0);
    frame();
    check("sat512.x", 32'(topLeftX), 312);
    repeat (39) frame();
    check_all("lexact", 0, 36, 1'b0, 1'b0, 0);
    frame();
    check_all("lwall", 0, 36, 1'b0, 1'b0, 0);
    repeat (15) frame();
    check("descL15.y", 32'(topLeftY), 51);
    check("descL15.dir", 32'(dirRight), 0);
    frame();
    check_all("descL16", 0, 52, 1'b1, 1'b0, 0);

    n = 0;
    while (!landed && n < 3000) begin
      frame();
      n++;
    end
    check_all("landed", 0, 404, 1'b0, 1'b1, 0);

    repeat (5) frame();
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("landed_hold", 0, 404, 1'b0, 1'b1, 0);

    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_all("wave1", 20, 20, 1'b1, 1'b0, 1);
    frame();
    check("wave1.idlex", 32'(topLeftX), 20);
    repeat (64) frame();
    check("speed68.x", 32'(topLeftX), 88);

    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check_all("wave2", 20, 20, 1'b1, 1'b0, 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (64) frame();
    check("speed76.x", 32'(topLeftX), 96);

    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (dirRight && n < 400) begin
      frame();
      n++;
    end
    repeat (3) frame();
    check("wave3.dir", 32'(dirRight), 0);
    check("wave3.wave", 32'(waveNum), 3);
    check("wave3.y", 32'(topLeftY), 36);

    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check_all("async_rst", 20, 20, 1'b1, 1'b0, 0);
    @(negedge clk);
    resetN = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("post_rst", 20, 20, 1'b1, 1'b0, 0);

    repeat (15) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("wave15", 32'(waveNum), 15);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("wave_sat", 32'(waveNum), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
